// File: rtl/inst_fetch_bus_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_bus_if_pkg
//  Description : Shared definitions for the instruction-fetch bus bridge:
//                FSM state encodings, the NOP instruction word and the
//                index of the IF/ID hold bit inside the pipeline stall vector.
//  Revision    : 1.0  initial release
// ============================================================================
package inst_fetch_bus_if_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,   // waiting for a fetch enable
        IF_BUSY = 2'd1,   // bus read outstanding
        IF_HOLD = 2'd2    // word presented until IF/ID accepts it
    } if_state_e;

    // Instruction word injected whenever nothing valid is available
    localparam logic [31:0] IF_NOP = 32'h0000_0000;

    // Bit of stall_i that freezes the IF/ID pipeline register
    localparam int IfIdStallBit = 1;

    // Width of the BUSY-cycle watchdog counter (TIMEOUT_CYC <= 255)
    localparam int IF_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/fetch_hit_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_hit_buf
//  Description : Single-entry last-fetch buffer. Holds {valid, tag, data} of
//                the most recent successfully fetched word and reports a hit
//                when the lookup address matches the stored tag.
//                Compiled only when IF_LAST_HIT_EN is defined.
//  Ports       : clk, rst (sync, active-low)
//                clr          - invalidate entry (flush)
//                wr_en        - capture wr_tag / wr_data
//                lookup_addr  - address to compare against the tag
//                hit, data    - match flag and stored word
//  Revision    : 1.0  initial release
// ============================================================================
`ifdef IF_LAST_HIT_EN
module fetch_hit_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_tag;
    logic [DATA_W-1:0] r_data;

    // A flush wins over a simultaneous write so a redirected stream never
    // re-uses a word fetched for the old path.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (clr) begin
            r_valid <= 1'b0;
        end else if (wr_en) begin
            r_valid <= 1'b1;
            r_tag   <= wr_tag;
            r_data  <= wr_data;
        end
    end

    assign hit  = r_valid && (lookup_addr == r_tag);
    assign data = r_data;

endmodule
`endif
`default_nettype wire

// File: rtl/inst_fetch_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_bus_if
//  Description : Bridges the core instruction-fetch port to a wait-stated
//                req/ack memory bus. Stalls the fetch stage while a read is
//                outstanding and presents the fetched word until IF/ID takes
//                it. One outstanding transaction, BUSY-cycle watchdog.
//  Macro       : IF_LAST_HIT_EN - adds a one-entry last-fetch buffer that
//                serves a repeated address without a bus transaction.
//  Ports       : clk, rst (sync, active-low)
//                cpu_ce_i, cpu_addr_i, cpu_data_o - core fetch port
//                stall_i[5:0], flush_i, stallreq_o - pipeline control
//                err_o                             - 1-cycle timeout pulse
//                bus_req_o, bus_addr_o, bus_data_i, bus_ack_i - memory bus
//  Revision    : 1.0  initial release
// ============================================================================
module inst_fetch_bus_if
    import inst_fetch_bus_if_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic [DATA_W-1:0] cpu_data_o,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    output logic              stallreq_o,
    output logic              err_o,
    output logic              bus_req_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    input  logic [DATA_W-1:0] bus_data_i,
    input  logic              bus_ack_i
);

    localparam logic [DATA_W-1:0]   NOP_WORD = DATA_W'(IF_NOP);
    localparam logic [IF_CNT_W-1:0] CNT_LAST = IF_CNT_W'(TIMEOUT_CYC - 1);

    if_state_e             r_state;
    if_state_e             w_state_nxt;
    logic                  r_bus_req;
    logic                  w_bus_req_nxt;
    logic [ADDR_W-1:0]     r_bus_addr;
    logic [ADDR_W-1:0]     w_bus_addr_nxt;
    logic [DATA_W-1:0]     r_cpu_data;
    logic [DATA_W-1:0]     w_cpu_data_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic [IF_CNT_W-1:0]   r_cnt;
    logic [IF_CNT_W-1:0]   w_cnt_nxt;
    logic                  r_flush_pending;
    logic                  w_flush_pending_nxt;

    logic                  w_buf_wr;
    logic                  w_hit;
    logic [DATA_W-1:0]     w_hit_data;
    logic                  w_discard;
    logic                  w_timeout;
    logic                  w_unused_stall;

    // Only the IF/ID hold bit matters to the fetch stage.
    assign w_unused_stall = ^{stall_i[5:2], stall_i[0]};

`ifdef IF_LAST_HIT_EN
    fetch_hit_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hit_buf (
        .clk         (clk),
        .rst         (rst),
        .clr         (flush_i),
        .wr_en       (w_buf_wr),
        .wr_tag      (r_bus_addr),
        .wr_data     (bus_data_i),
        .lookup_addr (cpu_addr_i),
        .hit         (w_hit),
        .data        (w_hit_data)
    );
`else
    logic w_unused_buf;
    assign w_unused_buf = w_buf_wr;
    assign w_hit        = 1'b0;
    assign w_hit_data   = '0;
`endif

    // A bus read cannot be cancelled, so a flush seen while BUSY (now or
    // earlier) turns the eventual ack into a discard.
    assign w_discard = r_flush_pending || flush_i;
    assign w_timeout = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= IF_IDLE;
            r_bus_req       <= 1'b0;
            r_bus_addr      <= '0;
            r_cpu_data      <= NOP_WORD;
            r_err           <= 1'b0;
            r_cnt           <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_bus_req       <= w_bus_req_nxt;
            r_bus_addr      <= w_bus_addr_nxt;
            r_cpu_data      <= w_cpu_data_nxt;
            r_err           <= w_err_nxt;
            r_cnt           <= w_cnt_nxt;
            r_flush_pending <= w_flush_pending_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_bus_req_nxt       = r_bus_req;
        w_bus_addr_nxt      = r_bus_addr;
        w_cpu_data_nxt      = r_cpu_data;
        w_err_nxt           = 1'b0;
        w_cnt_nxt           = r_cnt;
        w_flush_pending_nxt = r_flush_pending;
        w_buf_wr            = 1'b0;

        case (r_state)
            IF_IDLE: begin
                w_flush_pending_nxt = 1'b0;
                if (!cpu_ce_i) begin
                    w_cpu_data_nxt = NOP_WORD;
                end else if (!flush_i) begin
                    if (w_hit) begin
                        // Repeated address: serve from the buffer, skip the bus.
                        w_cpu_data_nxt = w_hit_data;
                        w_state_nxt    = IF_HOLD;
                    end else begin
                        w_bus_addr_nxt = cpu_addr_i;
                        w_bus_req_nxt  = 1'b1;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = IF_BUSY;
                    end
                end
            end

            IF_BUSY: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (flush_i) begin
                    w_flush_pending_nxt = 1'b1;
                end
                if (bus_ack_i) begin
                    // Ack has priority over a coincident timeout.
                    w_bus_req_nxt = 1'b0;
                    if (w_discard) begin
                        w_flush_pending_nxt = 1'b0;
                        w_cpu_data_nxt      = NOP_WORD;
                        w_state_nxt         = IF_IDLE;
                    end else begin
                        w_cpu_data_nxt = bus_data_i;
                        w_buf_wr       = 1'b1;
                        w_state_nxt    = IF_HOLD;
                    end
                end else if (w_timeout) begin
                    // Abandon the read and hand a NOP to the pipeline.
                    w_bus_req_nxt       = 1'b0;
                    w_cpu_data_nxt      = NOP_WORD;
                    w_err_nxt           = 1'b1;
                    w_flush_pending_nxt = 1'b0;
                    w_state_nxt         = w_discard ? IF_IDLE : IF_HOLD;
                end
            end

            IF_HOLD: begin
                if (flush_i) begin
                    w_cpu_data_nxt = NOP_WORD;
                    w_state_nxt    = IF_IDLE;
                end else if (!stall_i[IfIdStallBit]) begin
                    // IF/ID captures cpu_data_o on this edge.
                    w_state_nxt = IF_IDLE;
                end
            end

            default: begin
                w_bus_req_nxt  = 1'b0;
                w_cpu_data_nxt = NOP_WORD;
                w_state_nxt    = IF_IDLE;
            end
        endcase
    end

    // Gated by rst so the pipeline is never stalled while in reset.
    assign stallreq_o = rst && (((r_state == IF_IDLE) && cpu_ce_i && !flush_i) ||
                                (r_state == IF_BUSY));

    assign cpu_data_o = r_cpu_data;
    assign err_o      = r_err;
    assign bus_req_o  = r_bus_req;
    assign bus_addr_o = r_bus_addr;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_bus_if
//  Description : Scoreboard bench for inst_fetch_bus_if. Directed fetches
//                push expected bus addresses, request lengths, delivered
//                words and error events; a monitor pops and compares them
//                when the DUT raises a request, drops it, pulses err_o or
//                hands a word to IF/ID. A wait-stated memory model answers.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inst_fetch_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_o;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        stallreq_o;
    logic        err_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;

    int n_checks = 0;
    int n_errors = 0;
    int mem_wait = 0;

    logic [31:0] exp_addr[$];
    int          exp_len[$];
    logic [31:0] exp_word[$];
    logic [31:0] exp_err[$];

    inst_fetch_bus_if #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_o (cpu_data_o),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .stallreq_o (stallreq_o),
        .err_o      (err_o),
        .bus_req_o  (bus_req_o),
        .bus_addr_o (bus_addr_o),
        .bus_data_i (bus_data_i),
        .bus_ack_i  (bus_ack_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0004: return 32'h3401_1100;
            32'h0000_0020: return 32'hDEAD_BEEF;
            default:       return a ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model: acks mem_wait cycles after it first sees the request.
    initial begin
        int wait_cnt;
        wait_cnt   = 0;
        bus_ack_i  = 1'b0;
        bus_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_ack_i = 1'b0;
            if (rst === 1'b1 && bus_req_o === 1'b1) begin
                if (wait_cnt == mem_wait) begin
                    bus_ack_i  = 1'b1;
                    bus_data_i = mem_word(bus_addr_o);
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic prev_req;
        int   req_len;
        prev_req = 1'b0;
        req_len  = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev_req = 1'b0;
            end else begin
                if (bus_req_o && !prev_req) begin
                    if (exp_addr.size() == 0) chk("unexpected_req", bus_req_o, 1'b0);
                    else                      chk("sb_req_addr", bus_addr_o, exp_addr.pop_front());
                    req_len = 0;
                end
                if (bus_req_o) req_len++;
                if (!bus_req_o && prev_req && exp_len.size() != 0)
                    chk("sb_req_len", req_len, exp_len.pop_front());
                if (err_o) begin
                    if (exp_err.size() == 0) chk("unexpected_err", err_o, 1'b0);
                    else                     chk("sb_err_data", cpu_data_o, exp_err.pop_front());
                end
                // IF/ID takes the word when fetch is enabled and nothing holds it.
                if (cpu_ce_i && !stallreq_o && !stall_i[1] && !flush_i) begin
                    if (exp_word.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_capture: got word %h expected no capture", cpu_data_o);
                    end else begin
                        chk("sb_word", cpu_data_o, exp_word.pop_front());
                    end
                end
                prev_req = bus_req_o;
            end
        end
    end

    task automatic fetch(input logic [31:0] addr, input int wt, input int stall_cyc, input bit keep_ce);
        logic [31:0] w;
        w          = mem_word(addr);
        cpu_addr_i = addr;
        cpu_ce_i   = 1'b1;
        mem_wait   = wt;
        stall_i    = (stall_cyc > 0) ? 6'b000111 : 6'b000000;
        exp_addr.push_back(addr);
        exp_len.push_back(wt + 1);
        exp_word.push_back(w);
        step();
        chk("req_issued", bus_req_o, 1'b1);
        chk("req_addr", bus_addr_o, addr);
        chk("stallreq_busy", stallreq_o, 1'b1);
        repeat (wt + 1) step();
        chk("hold_data", cpu_data_o, w);
        chk("hold_stallreq", stallreq_o, 1'b0);
        for (int i = 0; i < stall_cyc; i++) begin
            step();
            chk("stall_data", cpu_data_o, w);
            chk("stall_no_req", bus_req_o, 1'b0);
        end
        stall_i = 6'b000000;
        step();
        if (!keep_ce) cpu_ce_i = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        cpu_ce_i   = 1'b1;
        cpu_addr_i = 32'h0000_0004;
        stall_i    = 6'b000000;
        flush_i    = 1'b0;

        // 1. Reset held with fetch enabled
        step();
        step();
        chk("rst_req", bus_req_o, 1'b0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_data", cpu_data_o, 32'h0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_stallreq", stallreq_o, 1'b0);
        rst = 1'b1;
        #1;
        chk("post_rst_stallreq", stallreq_o, 1'b1);

        // 2. Single fetch, 3 wait cycles
        fetch(32'h0000_0004, 3, 0, 1'b0);

        // 3. HOLD under IF/ID stall for 4 cycles
        fetch(32'h0000_0008, 0, 4, 1'b1);

        // 4. Flush while BUSY, ack 2 cycles later is discarded
        cpu_addr_i = 32'h0000_0020;
        mem_wait   = 3;
        exp_addr.push_back(32'h0000_0020);
        exp_len.push_back(4);
        step();
        step();
        flush_i    = 1'b1;
        cpu_addr_i = 32'h0000_0040;
        step();
        flush_i = 1'b0;
        step();
        step();
        chk("flush_data_nop", cpu_data_o, 32'h0);
        chk("flush_no_req", bus_req_o, 1'b0);
        chk("flush_idle_stallreq", stallreq_o, 1'b1);
        mem_wait = 0;
        exp_addr.push_back(32'h0000_0040);
        exp_len.push_back(1);
        exp_word.push_back(mem_word(32'h0000_0040));
        step();
        chk("redirect_addr", bus_addr_o, 32'h0000_0040);
        step();
        chk("redirect_data", cpu_data_o, mem_word(32'h0000_0040));
        step();

        // 5a. Timeout with no ack
        cpu_addr_i = 32'h0000_0080;
        mem_wait   = -1;
        exp_addr.push_back(32'h0000_0080);
        exp_len.push_back(8);
        exp_word.push_back(32'h0);
        exp_err.push_back(32'h0);
        step();
        repeat (7) step();
        chk("to_req_still_high", bus_req_o, 1'b1);
        chk("to_no_early_err", err_o, 1'b0);
        step();
        chk("to_req_dropped", bus_req_o, 1'b0);
        chk("to_err_pulse", err_o, 1'b1);
        chk("to_data_nop", cpu_data_o, 32'h0);
        chk("to_stallreq", stallreq_o, 1'b0);
        step();
        chk("to_err_one_cycle", err_o, 1'b0);

        // 5b. Ack in the timeout cycle wins
        fetch(32'h0000_0084, 7, 0, 1'b0);
        chk("ack_at_timeout_err", err_o, 1'b0);

        // 6. Repeated fetch of the same address
        fetch(32'h0000_0100, 0, 0, 1'b0);
`ifdef IF_LAST_HIT_EN
        cpu_addr_i = 32'h0000_0100;
        cpu_ce_i   = 1'b1;
        exp_word.push_back(mem_word(32'h0000_0100));
        #1;
        chk("hit_stallreq_first", stallreq_o, 1'b1);
        step();
        chk("hit_data", cpu_data_o, mem_word(32'h0000_0100));
        chk("hit_no_req", bus_req_o, 1'b0);
        chk("hit_stallreq_drop", stallreq_o, 1'b0);
        step();
        cpu_ce_i = 1'b0;
        step();
`else
        fetch(32'h0000_0100, 0, 0, 1'b0);
`endif
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        fetch(32'h0000_0100, 0, 0, 1'b0);

        repeat (4) step();
        chk("q_addr_empty", exp_addr.size(), 0);
        chk("q_len_empty", exp_len.size(), 0);
        chk("q_word_empty", exp_word.size(), 0);
        chk("q_err_empty", exp_err.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
